// File: rtl/fp_mant_addsub_stage.sv
// Mantissa add/subtract stage of the FP adder: signed-magnitude add with IEEE zero-sign rules,
// elastic valid/ready output through a 2-entry skid buffer. FP_ADD_LZC_EN adds a leading-zero count.
module fp_mant_addsub_stage #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8,
  parameter int GRS_W = 3,
  localparam int IN_W  = MAN_W + GRS_W,
  localparam int SUM_W = IN_W + 1,
  localparam int LZC_W = $clog2(SUM_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a_man,
  input  logic [IN_W-1:0]  in_b_man,
  input  logic             in_a_sign,
  input  logic             in_b_sign,
  input  logic             in_sub,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_man,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_carry,
  output logic [LZC_W-1:0] out_lzc
);

  typedef struct packed {
    logic [SUM_W-1:0] man;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             zero;
`ifdef FP_ADD_LZC_EN
    logic [LZC_W-1:0] lzc;
`endif
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

`ifdef FP_ADD_LZC_EN
  function automatic logic [LZC_W-1:0] lzc_f(input logic [SUM_W-1:0] v);
    logic [LZC_W-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = SUM_W - 1; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + LZC_W'(1);
      end
    end
    return n;
  endfunction
`endif

  logic             eff_b, same, a_ge_b;
  logic [SUM_W-1:0] a_x, b_x, mag;
  entry_t           new_e, main_e, skid_e;

  always_comb begin
    a_x    = {1'b0, in_a_man};
    b_x    = {1'b0, in_b_man};
    eff_b  = in_b_sign ^ in_sub;
    same   = (eff_b == in_a_sign);
    a_ge_b = (in_a_man >= in_b_man);
    if (same)        mag = a_x + b_x;
    else if (a_ge_b) mag = a_x - b_x;
    else             mag = b_x - a_x;
    new_e      = '0;
    new_e.man  = mag;
    new_e.exp  = in_exp;
    new_e.zero = (mag == '0);
    // Exact cancellation of opposite signs yields +0; like-signed zeros keep their sign.
    if (same)             new_e.sign = in_a_sign;
    else if (mag == '0)   new_e.sign = 1'b0;
    else                  new_e.sign = a_ge_b ? in_a_sign : eff_b;
`ifdef FP_ADD_LZC_EN
    new_e.lzc  = lzc_f(mag);
`endif
  end

  state_t state, state_nx;
  logic   accept, xfer, load_main, load_skid, pop_skid;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: if (accept) begin load_main = 1'b1; state_nx = ONE; end
      ONE: begin
        if (accept && xfer)       load_main = 1'b1;
        else if (accept)          begin load_skid = 1'b1; state_nx = FULL; end
        else if (xfer)            state_nx = EMPTY;
      end
      FULL: if (xfer) begin pop_skid = 1'b1; state_nx = ONE; end
      default: state_nx = EMPTY;
    endcase
  end

  // Handshake flags are flopped from the next state so neither depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_e    <= '0;
      skid_e    <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != FULL);
      out_valid <= (state_nx != EMPTY);
      if (load_main)     main_e <= new_e;
      else if (pop_skid) main_e <= skid_e;
      if (load_skid)     skid_e <= new_e;
    end
  end

  assign out_man   = main_e.man;
  assign out_sign  = main_e.sign;
  assign out_exp   = main_e.exp;
  assign out_zero  = main_e.zero;
  assign out_carry = main_e.man[SUM_W-1];
`ifdef FP_ADD_LZC_EN
  assign out_lzc   = main_e.lzc;
`else
  assign out_lzc   = '0;
`endif

endmodule

// File: tb/tb_fp_mant_addsub_stage.sv
// Directed bench for fp_mant_addsub_stage: signed-integer reference model plus scoreboard queue,
// hand-computed literal checks, back-pressure and asynchronous reset scenarios.
module tb_fp_mant_addsub_stage;
  localparam int SUM_W = 28;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [26:0] in_a_man = '0, in_b_man = '0;
  logic        in_a_sign = 1'b0, in_b_sign = 1'b0, in_sub = 1'b0;
  logic [7:0]  in_exp = '0, out_exp;
  logic [27:0] out_man;
  logic        out_sign, out_zero, out_carry;
  logic [4:0]  out_lzc;

  fp_mant_addsub_stage #(.MAN_W(24), .EXP_W(8), .GRS_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_man(in_a_man), .in_b_man(in_b_man), .in_a_sign(in_a_sign), .in_b_sign(in_b_sign),
    .in_sub(in_sub), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_man(out_man), .out_sign(out_sign), .out_exp(out_exp), .out_zero(out_zero),
    .out_carry(out_carry), .out_lzc(out_lzc));

  always #5 clk = ~clk;

  typedef struct { logic [26:0] a, b; logic as, bs, sub; logic [7:0] e; } vec_t;
  typedef struct { logic [27:0] man; logic sign; logic [7:0] e; logic zero, carry; logic [4:0] lzc; } res_t;

  int   n_cmp = 0, n_err = 0, n_xfer = 0;
  res_t q[$];
  vec_t vq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: treat operands as signed integers, add, split into magnitude and sign.
  function automatic res_t model(input vec_t v);
    res_t   r;
    longint va, vb, s, m;
    logic   effb;
    int     n;
    effb = v.bs ^ v.sub;
    va = v.as ? -longint'(v.a) : longint'(v.a);
    vb = effb ? -longint'(v.b) : longint'(v.b);
    s  = va + vb;
    m  = (s < 0) ? -s : s;
    r.man = m[27:0];
    if (s < 0)      r.sign = 1'b1;
    else if (s > 0) r.sign = 1'b0;
    else            r.sign = (v.as == effb) ? v.as : 1'b0;
    r.e = v.e;
    r.zero = (m == 0);
    r.carry = r.man[27];
    n = 0;
    for (int i = SUM_W - 1; i >= 0; i--) begin
      if (r.man[i]) break;
      n++;
    end
`ifdef FP_ADD_LZC_EN
    r.lzc = 5'(n);
`else
    r.lzc = 5'(0 * n);
`endif
    return r;
  endfunction

  function automatic vec_t mk(input logic [26:0] a, b, input logic as, bs, sub, input logic [7:0] e);
    vec_t v;
    v.a = a; v.b = b; v.as = as; v.bs = bs; v.sub = sub; v.e = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_a_man = v.a; in_b_man = v.b;
    in_a_sign = v.as; in_b_sign = v.bs; in_sub = v.sub; in_exp = v.e;
  endtask

  // Scoreboard: push on accept, pop on transfer, and hold checks while stalled.
  logic        hold = 1'b0;
  logic [27:0] h_man;
  logic        h_sign;
  logic [7:0]  h_exp;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold && out_valid) begin
        check("stall_man", out_man, h_man);
        check("stall_sign", out_sign, h_sign);
        check("stall_exp", out_exp, h_exp);
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          res_t r;
          r = q.pop_front();
          check("sb_man", out_man, r.man);
          check("sb_sign", out_sign, r.sign);
          check("sb_exp", out_exp, r.e);
          check("sb_zero", out_zero, r.zero);
          check("sb_carry", out_carry, r.carry);
          check("sb_lzc", out_lzc, r.lzc);
        end
      end
      hold = out_valid && !out_ready;
      h_man = out_man; h_sign = out_sign; h_exp = out_exp;
      if (in_valid && in_ready) begin
        vec_t v;
        v = mk(in_a_man, in_b_man, in_a_sign, in_b_sign, in_sub, in_exp);
        q.push_back(model(v));
      end
    end
  end

  // One beat with out_ready high; literal outputs checked 1 cycle after accept.
  task automatic single(input string name, input vec_t v, input logic [27:0] man, input logic sign,
                        input logic zero, input logic carry, input logic [4:0] lzc);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(v);
    check({name, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_man"}, out_man, man);
    check({name, "_sign"}, out_sign, sign);
    check({name, "_zero"}, out_zero, zero);
    check({name, "_carry"}, out_carry, carry);
    check({name, "_lzc"}, out_lzc, lzc);
    check({name, "_exp"}, out_exp, v.e);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((q.size() != 0 || out_valid) && g < 50) begin @(posedge clk); g++; end
    #1;
    check({name, "_drain_timeout"}, (g >= 50), 0);
  endtask

  logic [4:0] lz3, lz28;
  int idx, x0, g;
  logic acc;

  initial begin
`ifdef FP_ADD_LZC_EN
    lz3 = 5'd3; lz28 = 5'd28;
`else
    lz3 = 5'd0; lz28 = 5'd0;
`endif
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_man", out_man, 0);
    check("rst_zero", out_zero, 0);
    check("rst_lzc", out_lzc, 0);
    @(posedge clk); #1 rst = 1'b0;

    single("carry", mk(27'h6000000, 27'h5000000, 0, 0, 0, 8'h81), 28'hB000000, 0, 0, 1, 5'd0);
    single("bbig", mk(27'h5000000, 27'h6000000, 0, 0, 1, 8'h7F), 28'h1000000, 1, 0, 0, lz3);
    single("cancel", mk(27'h4000000, 27'h4000000, 1, 0, 0, 8'h10), 28'h0, 0, 1, 0, lz28);
    single("negzero", mk(27'h0, 27'h0, 1, 1, 0, 8'h00), 28'h0, 1, 1, 0, lz28);
    drain("single");

    // Back-pressure: out_ready low, four beats offered, only two fit.
    vq.delete();
    vq.push_back(mk(27'h0123456, 27'h0000FFF, 0, 0, 0, 8'h01));
    vq.push_back(mk(27'h0000100, 27'h4000000, 1, 1, 1, 8'h02));
    vq.push_back(mk(27'h7FFFFFF, 27'h7FFFFFF, 0, 0, 0, 8'h03));
    vq.push_back(mk(27'h2000000, 27'h2000001, 1, 0, 0, 8'h04));
    x0 = n_xfer; idx = 0; acc = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      if (acc) idx++;
      #1;
      out_ready = 1'b0;
      if (idx < 4) drive(vq[idx]); else in_valid = 1'b0;
      if (idx == 2) check("bp_ready_low", in_ready, 0);
      acc = in_valid & in_ready;
    end
    check("bp_accepted", idx, 2);
    g = 0;
    while (idx < 4 && g < 40) begin
      @(posedge clk);
      if (acc) idx++;
      #1;
      out_ready = 1'b1;
      if (idx < 4) drive(vq[idx]); else in_valid = 1'b0;
      acc = in_valid & in_ready;
      g++;
    end
    in_valid = 1'b0;
    check("bp_feed_timeout", (g >= 40), 0);
    drain("bp");
    check("bp_xfer_count", n_xfer - x0, 4);

    // Mixed stream with pseudo-random back-pressure.
    vq.delete();
    for (int i = 0; i < 12; i++)
      vq.push_back(mk(27'($urandom), 27'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'(i)));
    vq.push_back(mk(27'h1234567, 27'h1234567, 0, 0, 1, 8'hAA));
    idx = 0; acc = 1'b0; g = 0;
    while (idx < vq.size() && g < 200) begin
      @(posedge clk);
      if (acc) idx++;
      #1;
      out_ready = 1'($urandom);
      if (idx < vq.size()) drive(vq[idx]); else in_valid = 1'b0;
      acc = in_valid & in_ready;
      g++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("mix_feed_timeout", (g >= 200), 0);
    drain("mix");

    // Reset while FULL.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(mk(27'h0000010, 27'h0000001, 0, 0, 0, 8'h55));
    @(posedge clk); #1;
    drive(mk(27'h0000020, 27'h0000002, 0, 0, 0, 8'h66));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_man", out_man, 0);
    check("arst_exp", out_exp, 0);
    @(posedge clk); #1 rst = 1'b0;
    single("post_rst", mk(27'h0000300, 27'h0000100, 1, 1, 1, 8'h77), 28'h0000200, 1, 0, 0,
`ifdef FP_ADD_LZC_EN
           5'd18
`else
           5'd0
`endif
          );
    drain("post_rst");
    check("post_rst_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
